// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode 7-segment scan driver with LZB, decimal points, blink and guard blanking.
// Optional macro FND_HEX_EN: decode 0xA..0xF as hex glyphs instead of blank.
module fnd_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_lzb,
  input  logic [DIGITS-1:0]     i_blink_mask,
  output logic [DIGITS-1:0]     o_digit,
  output logic [7:0]            o_font,
  output logic                  o_frame_tick
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              bph_q, bph_d;
  logic [DIGITS-1:0] digit_q, digit_d;
  logic [7:0]        font_q, font_d;
  logic              tick_q, tick_d;

  logic              slot_end_s;
  logic              last_digit_s;
  logic              upper_zero_s;
  logic [DIGITS-1:0] lzb_blank_s;
  logic [DIGITS-1:0] digit_sel_s;
  logic [3:0]        cur_bcd_s;
  logic              cur_dp_s;
  logic              cur_blink_s;
  logic              cur_lzb_s;
  logic [7:0]        glyph_s;

  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] f;
    case (v)
      4'h0:    f = 8'hC0;
      4'h1:    f = 8'hF9;
      4'h2:    f = 8'hA4;
      4'h3:    f = 8'hB0;
      4'h4:    f = 8'h99;
      4'h5:    f = 8'h92;
      4'h6:    f = 8'h82;
      4'h7:    f = 8'hF8;
      4'h8:    f = 8'h80;
      4'h9:    f = 8'h98;
`ifdef FND_HEX_EN
      4'hA:    f = 8'h88;
      4'hB:    f = 8'h83;
      4'hC:    f = 8'hC6;
      4'hD:    f = 8'hA1;
      4'hE:    f = 8'h86;
      4'hF:    f = 8'h8E;
`endif
      default: f = 8'hFF;
    endcase
    return f;
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    fcnt_d       = fcnt_q;
    bph_d        = bph_q;
    digit_d      = {DIGITS{1'b1}};
    font_d       = 8'hFF;
    tick_d       = 1'b0;
    slot_end_s   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    last_digit_s = (idx_q == IDX_W'(DIGITS - 1));
    upper_zero_s = 1'b1;
    lzb_blank_s  = '0;
    digit_sel_s  = '1;
    cur_bcd_s    = 4'h0;
    cur_dp_s     = 1'b0;
    cur_blink_s  = 1'b0;
    cur_lzb_s    = 1'b0;

    // Walk from the most significant digit down so each digit knows whether all above are zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero_s   = upper_zero_s & (i_bcd[4*k +: 4] == 4'h0);
      lzb_blank_s[k] = (k != 0) ? upper_zero_s : 1'b0;
    end

    for (int k = 0; k < DIGITS; k++) begin
      digit_sel_s[k] = (idx_q == IDX_W'(k)) ? 1'b0 : 1'b1;
      cur_bcd_s      = (idx_q == IDX_W'(k)) ? i_bcd[4*k +: 4]  : cur_bcd_s;
      cur_dp_s       = (idx_q == IDX_W'(k)) ? i_dp[k]          : cur_dp_s;
      cur_blink_s    = (idx_q == IDX_W'(k)) ? i_blink_mask[k]  : cur_blink_s;
      cur_lzb_s      = (idx_q == IDX_W'(k)) ? lzb_blank_s[k]   : cur_lzb_s;
    end

    glyph_s = decode(cur_bcd_s);
    if (i_lzb && cur_lzb_s) begin
      glyph_s[6:0] = 7'h7F;
    end else begin
      glyph_s[6:0] = glyph_s[6:0];
    end
    glyph_s[7] = ~cur_dp_s;
    if (cur_blink_s && !bph_q) begin
      glyph_s = 8'hFF;
    end else begin
      glyph_s = glyph_s;
    end

    if (i_en) begin
      font_d  = glyph_s;
      digit_d = (cnt_q < CNT_W'(GUARD)) ? {DIGITS{1'b1}} : digit_sel_s;
      if (slot_end_s) begin
        cnt_d = '0;
        idx_d = last_digit_s ? '0 : idx_q + IDX_W'(1);
        if (last_digit_s) begin
          tick_d = 1'b1;
          if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
            fcnt_d = '0;
            bph_d  = ~bph_q;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end else begin
          tick_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // Parking the prescaler at 0 makes the guard interval precede the held digit on resume.
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      bph_q   <= 1'b1;
      digit_q <= {DIGITS{1'b1}};
      font_q  <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      bph_q   <= bph_d;
      digit_q <= digit_d;
      font_q  <= font_d;
      tick_q  <= tick_d;
    end
  end

  assign o_digit      = digit_q;
  assign o_font       = font_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomised bench for fnd_scan_controller against a slot-counting behavioural model.
module tb_fnd_scan_controller;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int GUARD        = 2;
  localparam int BLINK_FRAMES = 2;
`ifdef FND_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] bcd = 16'h1234;
  logic [3:0]  dp  = 4'h0;
  logic        lzb = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [3:0]  o_digit;
  logic [7:0]  o_font;
  logic        o_tick;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_on    = 1'b0;

  fnd_scan_controller #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_bcd(bcd), .i_dp(dp), .i_lzb(lzb),
    .i_blink_mask(mask), .o_digit(o_digit), .o_font(o_font), .o_frame_tick(o_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] glyph(input int v);
    case (v)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h98;
      10: return HEX ? 8'h88 : 8'hFF;
      11: return HEX ? 8'h83 : 8'hFF;
      12: return HEX ? 8'hC6 : 8'hFF;
      13: return HEX ? 8'hA1 : 8'hFF;
      14: return HEX ? 8'h86 : 8'hFF;
      default: return HEX ? 8'h8E : 8'hFF;
    endcase
  endfunction

  // Font expected for digit d given the visible flag, from the current inputs.
  function automatic logic [7:0] model_font(input int d, input bit visible);
    logic [7:0] f;
    int v;
    v = (bcd >> (4 * d)) & 15;
    if (mask[d] && !visible) return 8'hFF;
    f = glyph(v);
    if (lzb && d > 0 && (bcd >> (4 * d)) == 16'h0) f = 8'hFF;
    if (dp[d]) f = f & 8'h7F;
    return f;
  endfunction

  // Model: m_pos is the position inside the current slot, m_slots counts completed slots.
  int         m_pos   = 0;
  int         m_slots = 0;
  logic [3:0] e_digit = 4'hF;
  logic [7:0] e_font  = 8'hFF;
  logic       e_tick  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos <= 0; m_slots <= 0;
      e_digit <= 4'hF; e_font <= 8'hFF; e_tick <= 1'b0;
    end else if (!en) begin
      m_pos <= 0;
      e_digit <= 4'hF; e_font <= 8'hFF; e_tick <= 1'b0;
    end else begin
      e_digit <= (m_pos < GUARD) ? 4'hF : ~(4'b0001 << (m_slots % DIGITS));
      e_font  <= model_font(m_slots % DIGITS, ((m_slots / DIGITS) / BLINK_FRAMES) % 2 == 0);
      e_tick  <= (m_pos == SCAN_DIV - 1) && (m_slots % DIGITS == DIGITS - 1);
      if (m_pos == SCAN_DIV - 1) begin
        m_pos <= 0; m_slots <= m_slots + 1;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_digit", {28'h0, o_digit}, {28'h0, e_digit});
      check("model_font",  {24'h0, o_font},  {24'h0, e_font});
      check("model_tick",  {31'h0, o_tick},  {31'h0, e_tick});
    end
  end

  task automatic wait_digit(input string name, input logic [3:0] d, input logic [7:0] f);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (o_digit === d) begin
        check(name, {24'h0, o_font}, {24'h0, f});
        found = 1'b1;
      end
    end
    if (!found) check({name, "_timeout"}, {28'h0, o_digit}, {28'h0, d});
  endtask

  task automatic release_checks();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("post_reset_digit", {28'h0, o_digit}, (i < 3) ? 32'hF : 32'hE);
    end
    check("post_reset_font", {24'h0, o_font}, 32'h99);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #1 check("reset_digit", {28'h0, o_digit}, 32'hF);
    check("reset_font", {24'h0, o_font}, 32'hFF);
    check("reset_tick", {31'h0, o_tick}, 32'h0);
    @(posedge clk); #1 rst = 1'b0; en = 1'b1; chk_on = 1'b1;
    release_checks();

    // Mid-slot asynchronous reset while digit 1 is lit
    wait_digit("seq_d1", 4'b1101, 8'hB0);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("midslot_reset_digit", {28'h0, o_digit}, 32'hF);
    check("midslot_reset_font", {24'h0, o_font}, 32'hFF);
    @(posedge clk); #1 rst = 1'b0;
    release_checks();

    wait_digit("seq_d2", 4'b1011, 8'hA4);
    wait_digit("seq_d3", 4'b0111, 8'hF9);
    n = 0;
    repeat (64) begin @(negedge clk); if (o_tick) n++; end
    check("ticks_per_64", n, 2);
    n = 0;
    repeat (32) begin @(negedge clk); if (o_digit == 4'b1110) n++; end
    check("slot_lit_cycles", n, 6);

    lzb = 1'b1; bcd = 16'h0050;
    wait_digit("lzb_d3", 4'b0111, 8'hFF);
    wait_digit("lzb_d2", 4'b1011, 8'hFF);
    wait_digit("lzb_d1", 4'b1101, 8'h92);
    wait_digit("lzb_d0", 4'b1110, 8'hC0);
    bcd = 16'h0000;
    wait_digit("lzb_zero_d1", 4'b1101, 8'hFF);
    wait_digit("lzb_zero_d0", 4'b1110, 8'hC0);

    lzb = 1'b0; dp = 4'b0100; bcd = 16'h1234;
    wait_digit("dp_d2", 4'b1011, 8'h24);

    dp = 4'h0; mask = 4'b0001;
    n = 0;
    repeat (256) begin @(negedge clk); if (o_digit == 4'b1110 && o_font != 8'hFF) n++; end
    check("blink_visible_cycles", n, 24);

    mask = 4'h0; bcd = 16'hABCD;
    wait_digit("hex_d3", 4'b0111, HEX ? 8'h88 : 8'hFF);
    wait_digit("hex_d2", 4'b1011, HEX ? 8'h83 : 8'hFF);
    wait_digit("hex_d1", 4'b1101, HEX ? 8'hC6 : 8'hFF);
    wait_digit("hex_d0", 4'b1110, HEX ? 8'hA1 : 8'hFF);

    // Drop enable while digit 2 is lit, then resume
    wait_digit("en_drop_d2", 4'b1011, HEX ? 8'h83 : 8'hFF);
    en = 1'b0;
    @(negedge clk);
    check("en_off_digit", {28'h0, o_digit}, 32'hF);
    check("en_off_font", {24'h0, o_font}, 32'hFF);
    repeat (5) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("resume_digit", {28'h0, o_digit}, (i < 2 || i == 8) ? 32'hF : 32'hB);
    end

    repeat (150) begin
      int k;
      bcd = 16'($urandom);
      k = $urandom_range(0, 4);
      bcd = bcd & (16'hFFFF >> (4 * k));
      dp = 4'($urandom);
      lzb = 1'($urandom);
      mask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 30) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
